// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: frame width, transmitter states and
// bit-order selectors used by both the transmitter and the matching receiver.
package serial_link_pkg;

    localparam int SER_WIDTH = 4;

    localparam bit MSB_FIRST_C = 1'b1;
    localparam bit LSB_FIRST_C = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle of the transmitter. The word source
// takes the master modport and the transmitter takes the slave modport.
interface piso_tx_if
    import serial_link_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pdata;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    modport master (
        output load_valid,
        output pdata,
        input  load_ready,
        input  dout,
        input  dout_valid,
        input  frame_start,
        input  frame_done,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  pdata,
        output load_ready,
        output dout,
        output dout_valid,
        output frame_start,
        output frame_done,
        output busy
    );

endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word over valid/ready and emits
// it one bit per enabled clock, with frame markers and gapless back-to-back frames.
module piso_tx
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = MSB_FIRST_C
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ce,
    piso_tx_if.slave bus
);

    localparam int             CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  PENULT  = CW'(WIDTH - 2);

    tx_state_t        state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             dout_r;
    logic             dout_valid_r;
    logic             frame_start_r;
    logic             frame_done_r;
    logic             busy_r;

    logic             load_ready;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] shifted;

    // A new word is only taken while idle or on the last bit of a frame, so
    // back-to-back frames chain without a gap.
    assign load_ready = rst & ce & ((state == IDLE) | ((state == SHIFT) & (cnt == LAST)));
    assign accept     = bus.load_valid & load_ready;

    always_comb begin
        first_bit = 1'b0;
        next_bit  = 1'b0;
        shifted   = '0;
        if (MSB_FIRST) begin
            first_bit = bus.pdata[WIDTH-1];
            next_bit  = sreg[WIDTH-2];
            shifted   = {sreg[WIDTH-2:0], 1'b0};
        end else begin
            first_bit = bus.pdata[0];
            next_bit  = sreg[1];
            shifted   = {1'b0, sreg[WIDTH-1:1]};
        end
    end

    // With ce low everything holds, so pulse outputs stretch across the stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            sreg          <= '0;
            cnt           <= '0;
            dout_r        <= 1'b0;
            dout_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                state         <= SHIFT;
                sreg          <= bus.pdata;
                cnt           <= '0;
                dout_r        <= first_bit;
                dout_valid_r  <= 1'b1;
                frame_start_r <= 1'b1;
                frame_done_r  <= 1'b0;
                busy_r        <= 1'b1;
            end else if (state == SHIFT) begin
                if (cnt == LAST) begin
                    state         <= IDLE;
                    sreg          <= '0;
                    cnt           <= '0;
                    dout_r        <= 1'b0;
                    dout_valid_r  <= 1'b0;
                    frame_start_r <= 1'b0;
                    frame_done_r  <= 1'b0;
                    busy_r        <= 1'b0;
                end else begin
                    sreg          <= shifted;
                    cnt           <= cnt + CW'(1);
                    dout_r        <= next_bit;
                    frame_start_r <= 1'b0;
                    frame_done_r  <= (cnt == PENULT);
                end
            end
        end
    end

    assign bus.load_ready  = load_ready;
    assign bus.dout        = dout_r;
    assign bus.dout_valid  = dout_valid_r;
    assign bus.frame_start = frame_start_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx: an MSB-first instance for framing,
// stall and reset behaviour, and an LSB-first instance looped into a receiver model.
module tb_piso_tx;
    import serial_link_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst;
    logic ce;

    int testCount = 0;
    int failCount = 0;

    logic [W-1:0]   rxWord;
    logic [W-1:0]   bits4;
    logic [2*W-1:0] bits8;

    piso_tx_if #(.WIDTH(W)) tx_if ();
    piso_tx_if #(.WIDTH(W)) lsb_if ();

    piso_tx #(.WIDTH(W), .MSB_FIRST(MSB_FIRST_C)) u_msb (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (tx_if)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(LSB_FIRST_C)) u_lsb (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (lsb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model: LSB-first serial-in parallel-out register sharing ce.
    always @(posedge clk or negedge rst) begin
        if (!rst)
            rxWord <= '0;
        else if (ce && lsb_if.dout_valid)
            rxWord <= {lsb_if.dout, rxWord[W-1:1]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Packs {dout, dout_valid, frame_start, frame_done, busy} of the MSB instance.
    task automatic checkTx(input string tag, input logic [4:0] expected);
        checkOutput(tag, {3'b000, tx_if.dout, tx_if.dout_valid, tx_if.frame_start,
                          tx_if.frame_done, tx_if.busy}, {3'b000, expected});
    endtask

    task automatic checkLsb(input string tag, input logic [4:0] expected);
        checkOutput(tag, {3'b000, lsb_if.dout, lsb_if.dout_valid, lsb_if.frame_start,
                          lsb_if.frame_done, lsb_if.busy}, {3'b000, expected});
    endtask

    task automatic applyStimulus(input logic valid, input logic [W-1:0] word);
        tx_if.load_valid = valid;
        tx_if.pdata      = word;
    endtask

    initial begin
        rst = 1'b0;
        ce  = 1'b1;
        applyStimulus(1'b0, '0);
        lsb_if.load_valid = 1'b0;
        lsb_if.pdata      = '0;
        #1;
        checkTx("reset_outputs", 5'b00000);
        checkOutput("reset_ready", {7'd0, tx_if.load_ready}, 8'd0);

        rst = 1'b1;
        tick();
        tick();

        // Reset asserted mid-simulation with a load pending.
        rst = 1'b0;
        applyStimulus(1'b1, 4'b1011);
        #1;
        checkOutput("rst_ready_forced", {7'd0, tx_if.load_ready}, 8'd0);
        tick();
        tick();
        checkTx("rst_hold_outputs", 5'b00000);
        applyStimulus(1'b0, 4'b1011);
        rst = 1'b1;
        #1;
        checkOutput("idle_ready", {7'd0, tx_if.load_ready}, 8'd1);
        checkTx("idle_outputs", 5'b00000);

        // Single MSB-first frame.
        applyStimulus(1'b1, 4'b1011);
        tick();
        applyStimulus(1'b0, 4'b0000);
        bits4 = 4'b1011;
        for (int i = 0; i < W; i++) begin
            checkTx($sformatf("single_bit%0d", i),
                    {bits4[W-1-i], 1'b1, (i == 0), (i == W-1), 1'b1});
            if (i == W-1)
                checkOutput("single_last_ready", {7'd0, tx_if.load_ready}, 8'd1);
            else
                checkOutput($sformatf("single_ready%0d", i), {7'd0, tx_if.load_ready}, 8'd0);
            tick();
        end
        checkTx("single_idle", 5'b00000);

        // Back-to-back frames, second word accepted on the last-bit edge.
        applyStimulus(1'b1, 4'b1011);
        tick();
        applyStimulus(1'b0, 4'b0000);
        bits8 = 8'b1011_0110;
        for (int i = 0; i < 2*W; i++) begin
            if (i == W-1)
                applyStimulus(1'b1, 4'b0110);
            checkTx($sformatf("b2b_bit%0d", i),
                    {bits8[2*W-1-i], 1'b1, (i == 0 || i == W), (i == W-1 || i == 2*W-1), 1'b1});
            tick();
            if (i == W-1)
                applyStimulus(1'b0, 4'b0000);
        end
        checkTx("b2b_idle", 5'b00000);

        // Clock-enable stall after the second bit.
        applyStimulus(1'b1, 4'b1100);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkTx("stall_bit0", 5'b11101);
        tick();
        checkTx("stall_bit1", 5'b11001);
        ce = 1'b0;
        #1;
        checkOutput("stall_ready", {7'd0, tx_if.load_ready}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkTx($sformatf("stall_hold%0d", i), 5'b11001);
        end
        ce = 1'b1;
        tick();
        checkTx("stall_bit2", 5'b01001);
        tick();
        checkTx("stall_bit3", 5'b01011);
        tick();
        checkTx("stall_idle", 5'b00000);

        // Load while busy is ignored, then reset mid-frame.
        applyStimulus(1'b1, 4'b1000);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkTx("busy_bit0", 5'b11101);
        tick();
        applyStimulus(1'b1, 4'b1111);
        #1;
        checkOutput("busy_ready", {7'd0, tx_if.load_ready}, 8'd0);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkTx("busy_ignored", 5'b01001);
        rst = 1'b0;
        #1;
        checkTx("abort_outputs", 5'b00000);
        #2;
        rst = 1'b1;
        for (int i = 0; i < W; i++) begin
            tick();
            checkTx($sformatf("abort_quiet%0d", i), 5'b00000);
        end
        checkOutput("abort_ready", {7'd0, tx_if.load_ready}, 8'd1);

        // LSB-first frame looped into the receiver model.
        lsb_if.load_valid = 1'b1;
        lsb_if.pdata      = 4'b0001;
        tick();
        lsb_if.load_valid = 1'b0;
        lsb_if.pdata      = 4'b0000;
        bits4 = 4'b0001;
        for (int i = 0; i < W; i++) begin
            checkLsb($sformatf("lsb_bit%0d", i), {bits4[i], 1'b1, (i == 0), (i == W-1), 1'b1});
            tick();
        end
        checkLsb("lsb_idle", 5'b00000);
        checkOutput("loopback_word", {4'd0, rxWord}, 8'b0000_0001);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
